hack_fetch: RTL and testbench
=============================

# hack_fetch

Instruction fetch stage of the Hack CPU. It holds the program counter, reads instruction words from ROM through a req/ack handshake, and presents one latched instruction at a time to the CPU datapath. On consume, the CPU either accepts the sequential PC+1 or redirects fetch to a jump target; the CPU supplies the target from the A register. The CPU decoder and the A-register input select (instruction vs. ALU output) are fed from this block's `instr` output.

## Interface
Parameters:
- `ADDR_W`, default 15: PC / ROM address width (Hack ROM32K).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `rom_addr`, out, ADDR_W: ROM read address; stable while `rom_req`=1.
- `rom_req`, out, 1: ROM read request.
- `rom_ack`, in, 1: ROM returns `rom_data` this cycle.
- `rom_data`, in, 16: instruction word, valid only when `rom_ack`=1.
- `instr`, out, 16: latched instruction to the CPU decoder and A-register input select.
- `instr_pc`, out, ADDR_W: address that `instr` was fetched from.
- `instr_valid`, out, 1: `instr` is valid and not yet consumed.
- `instr_take`, in, 1: CPU consumes `instr` this cycle.
- `jump`, in, 1: jump condition met; sampled only with `instr_take`.
- `jump_target`, in, ADDR_W: next PC when `jump`=1 (A register value, low ADDR_W bits).
- `fetch_wait_cycles`, out, 32: present only with `HACK_FETCH_STATS_EN` defined.

## Operation
- States:
  - IDLE: one cycle after reset.
  - REQ: request outstanding.
  - VALID: instruction held.
- IDLE -> REQ unconditionally. `rom_addr` = `pc` = 0.
- REQ:
  - `rom_req`=1 and `rom_addr`=`pc`.
  - On `rom_ack`=1, latch `instr`<=`rom_data` and `instr_pc`<=`pc`, then go to VALID.
  - Otherwise stay in REQ with address unchanged.
- VALID:
  - `instr_valid`=1 and `rom_req`=0.
  - On `instr_take`=1: `pc` <= `jump` ? `jump_target` : `instr_pc`+1, then go to REQ.
  - Otherwise hold `instr`, `instr_pc` and `instr_valid`.
- PC arithmetic is modulo 2^ADDR_W: 0x7FFF+1 -> 0x0000.
- Ignored inputs:
  - `rom_ack` outside REQ is ignored; the ROM must not ack unrequested.
  - `instr_take` outside VALID is ignored.
  - `jump` without `instr_take` in VALID is ignored.
- `instr` is never modified while `instr_valid`=1.

## Timing
- Reset values: state=IDLE, `pc`=0, `rom_addr`=0, `rom_req`=0, `instr`=0x0000, `instr_pc`=0, `instr_valid`=0, `fetch_wait_cycles`=0.
- `reset` has priority over every other input in the same cycle.
- Reset mid-REQ drops the request: `rom_req`=0 next cycle, and an ack arriving in the reset cycle is discarded.
- Reset mid-VALID clears `instr_valid` next cycle.
- Cycle timing from reset:
  - `reset` deasserted at cycle 0 (IDLE).
  - `rom_req` high from cycle 1.
  - With zero-wait ack in cycle 1, `instr_valid` is high in cycle 2.
- Take at cycle t:
  - `rom_req` with the new address at t+1.
  - With a zero-wait ROM, `instr_valid` at t+2.
  - Peak throughput is one instruction per 2 cycles.
- All outputs are registered; there is no combinational path from any input to any output.
- `rom_addr` changes only on the REQ entry edge.

## Configuration
- Macro: `HACK_FETCH_STATS_EN`.
- Defined:
  - Adds output `fetch_wait_cycles`.
  - Increments by 1 on every REQ cycle with `rom_ack`=0.
  - Saturates at 0xFFFFFFFF.
  - Cleared only by `reset`.
- Undefined: the port and counter are absent. Fetch behaviour is identical in both builds.

## Test plan
- Reset, then ROM acks every request immediately with data 0x1000+addr, CPU takes every VALID with `jump`=0 -> fetched `instr_pc` sequence 0,1,2,3, `instr` 0x1000..0x1003, `instr_valid` first high 2 cycles after reset release.
- ROM delays ack 3 cycles on address 5 -> `rom_addr` held at 5 with `rom_req`=1 for 4 cycles; with the macro defined, `fetch_wait_cycles` increases by exactly 3.
- Take with `jump`=1, `jump_target`=0x0040 at `instr_pc`=7 -> next `rom_addr`=0x0040, then 0x0041. `jump`=1 without take has no effect.
- CPU withholds `instr_take` for 5 cycles -> `instr`, `instr_pc` and `instr_valid` constant, `rom_req`=0 throughout.
- Sequential take at `instr_pc`=0x7FFF -> next `rom_addr`=0x0000.
- Assert `reset` during REQ at address 0x0123 while `rom_ack`=1 -> ack discarded, next cycle all outputs at reset values, followed by a fetch from address 0.

Source files
------------

// File: rtl/hack_fetch.sv
// Hack CPU instruction fetch: PC, ROM req/ack handshake, one latched instruction.
// Optional stall counter output fetch_wait_cycles when HACK_FETCH_STATS_EN is defined.
module hack_fetch #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_req,
  input  logic              rom_ack,
  input  logic [15:0]       rom_data,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_take,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target
`ifdef HACK_FETCH_STATS_EN
  ,
  output logic [31:0]       fetch_wait_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (rom_ack) begin
          instr_d = rom_data;
          ipc_d   = pc_q;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        // pc only moves here, so rom_addr changes only when entering REQ
        if (instr_take) begin
          pc_d    = jump ? jump_target : ipc_q + ADDR_W'(1);
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rom_req     = 1'b0;
    instr_valid = 1'b0;
    unique case (1'b1)
      (state_q == S_REQ):   rom_req     = 1'b1;
      (state_q == S_VALID): instr_valid = 1'b1;
      default: ;
    endcase
  end

  assign rom_addr = pc_q;
  assign instr    = instr_q;
  assign instr_pc = ipc_q;

`ifdef HACK_FETCH_STATS_EN
  logic [31:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    if (state_q == S_REQ && !rom_ack && wait_q != 32'hFFFF_FFFF)
      wait_d = wait_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end

  assign fetch_wait_cycles = wait_q;
`endif

endmodule

// File: tb/tb_hack_fetch.sv
// Self-checking bench for hack_fetch: directed scenarios plus randomized
// fetch/jump traffic checked against an address-sequence reference model.
module tb_hack_fetch;
  localparam int AW = 15;
  localparam logic [AW-1:0] MASK = '1;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rom_addr;
  logic          rom_req;
  logic          rom_ack;
  logic [15:0]   rom_data;
  logic [15:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_take;
  logic          jump;
  logic [AW-1:0] jump_target;
`ifdef HACK_FETCH_STATS_EN
  logic [31:0]   fetch_wait_cycles;
`endif

  int checks = 0;
  int failures = 0;
  logic [AW-1:0] exp_pc;
  int unsigned   exp_waits;

  hack_fetch #(.ADDR_W(AW)) dut (
    .clk(clk),
    .reset(reset),
    .rom_addr(rom_addr),
    .rom_req(rom_req),
    .rom_ack(rom_ack),
    .rom_data(rom_data),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .instr_take(instr_take),
    .jump(jump),
    .jump_target(jump_target)
`ifdef HACK_FETCH_STATS_EN
    ,
    .fetch_wait_cycles(fetch_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [AW-1:0] a);
    return 16'h1000 + 16'(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_waits(input string tag);
`ifdef HACK_FETCH_STATS_EN
    chk(tag, fetch_wait_cycles, exp_waits);
`else
    checks++;
`endif
  endtask

  // One full fetch: we are in a cycle where a request for exp_pc is expected.
  task automatic fetch_one(input int ack_dly, input int hold,
                           input logic do_jmp, input logic [AW-1:0] tgt);
    logic [AW-1:0] a;
    a = exp_pc;
    chk("req_hi", 32'(rom_req), 32'd1);
    chk("req_addr", 32'(rom_addr), 32'(a));
    chk("req_nvalid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < ack_dly; i++) begin
      rom_ack = 1'b0;
      step();
      exp_waits++;
      chk("wait_req", 32'(rom_req), 32'd1);
      chk("wait_addr", 32'(rom_addr), 32'(a));
    end
    rom_ack  = 1'b1;
    rom_data = rom_word(a);
    step();
    rom_ack  = 1'b0;
    rom_data = 16'hDEAD;
    chk("valid_hi", 32'(instr_valid), 32'd1);
    chk("valid_noreq", 32'(rom_req), 32'd0);
    chk("instr", 32'(instr), 32'(rom_word(a)));
    chk("instr_pc", 32'(instr_pc), 32'(a));
    for (int i = 0; i < hold; i++) begin
      jump        = 1'($urandom);
      jump_target = AW'($urandom);
      step();
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_noreq", 32'(rom_req), 32'd0);
      chk("hold_instr", 32'(instr), 32'(rom_word(a)));
      chk("hold_pc", 32'(instr_pc), 32'(a));
    end
    instr_take  = 1'b1;
    jump        = do_jmp;
    jump_target = tgt;
    step();
    instr_take  = 1'b0;
    jump        = 1'b0;
    exp_pc      = do_jmp ? tgt : ((a + 1) & MASK);
  endtask

  initial begin
    reset       = 1'b1;
    rom_ack     = 1'b0;
    rom_data    = 16'h0;
    instr_take  = 1'b0;
    jump        = 1'b0;
    jump_target = '0;
    exp_waits   = 0;
    exp_pc      = '0;
    step();
    step();
    chk("rst_req", 32'(rom_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_ipc", 32'(instr_pc), 32'd0);
    chk_waits("rst_waits");

    reset = 1'b0;
    chk("idle_req", 32'(rom_req), 32'd0);
    step();
    // sequential fetches 0..4, then 5 with a 3-cycle ack delay
    for (int k = 0; k < 5; k++) fetch_one(0, 0, 1'b0, '0);
    chk_waits("waits0");
    fetch_one(3, 0, 1'b0, '0);
    chk_waits("waits3");
    fetch_one(0, 0, 1'b0, '0);
    // jump at 7 with jump toggling while not taken
    fetch_one(0, 2, 1'b1, AW'(16'h0040));
    chk("jmp_addr", 32'(rom_addr), 32'h40);
    fetch_one(0, 0, 1'b0, '0);
    chk("jmp_next", 32'(rom_addr), 32'h41);
    // withhold take for 5 cycles
    fetch_one(1, 5, 1'b1, AW'(16'h7FFF));
    fetch_one(0, 0, 1'b0, '0);
    chk("wrap_addr", 32'(rom_addr), 32'h0);

    for (int k = 0; k < 40; k++)
      fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 3) == 0), AW'($urandom));
    chk_waits("waits_rand");

    // reset during REQ at 0x0123 with a simultaneous ack
    fetch_one(0, 0, 1'b1, AW'(16'h0123));
    chk("r_req", 32'(rom_req), 32'd1);
    chk("r_addr", 32'(rom_addr), 32'h123);
    reset    = 1'b1;
    rom_ack  = 1'b1;
    rom_data = 16'hBEEF;
    step();
    reset    = 1'b0;
    rom_ack  = 1'b0;
    exp_waits = 0;
    exp_pc    = '0;
    chk("r2_req", 32'(rom_req), 32'd0);
    chk("r2_valid", 32'(instr_valid), 32'd0);
    chk("r2_addr", 32'(rom_addr), 32'd0);
    chk("r2_instr", 32'(instr), 32'd0);
    chk("r2_ipc", 32'(instr_pc), 32'd0);
    chk_waits("r2_waits");
    step();
    fetch_one(0, 0, 1'b0, '0);
    chk("post_addr", 32'(rom_addr), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
